// File: rtl/i2s_transmitter.sv
// Mono I2S serializer: divides i_clk into BCLK/LRCLK and sends the held 24-bit sample on both slots.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing; standard I2S (one-BCLK delay) otherwise.
module i2s_transmitter #(
    parameter int BCLK_HALF_DIV = 8,
    parameter int SLOT_BITS     = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [23:0] i_sample,
    output logic        o_sample_req,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata
);

    localparam int DIV_W = $clog2(BCLK_HALF_DIV);

    if (BCLK_HALF_DIV < 2) begin : g_bad_div
        $error("i2s_transmitter: BCLK_HALF_DIV must be >= 2");
    end
    if (SLOT_BITS != 32) begin : g_bad_slot
        $error("i2s_transmitter: SLOT_BITS is fixed at 32");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [23:0]      hold;

    logic        tick;
    logic        fall_tick;
    logic [5:0]  bit_nxt;
    logic        frame_wrap;
    logic [23:0] hold_nxt;
    logic [31:0] slot;
    logic [4:0]  pos;
    logic [4:0]  sd_idx;
    logic        sdata_nxt;
    logic        lrclk_nxt;

    always_comb begin
        tick       = (div_cnt == DIV_W'(BCLK_HALF_DIV - 1));
        fall_tick  = tick && o_bclk;
        bit_nxt    = bit_cnt + 6'd1;
        frame_wrap = (bit_nxt == 6'd0);
        // The slot word must already reflect the sample latched on this same tick.
        hold_nxt   = frame_wrap ? i_sample : hold;
        slot       = {hold_nxt, 8'h00};
        pos        = bit_nxt[4:0];
`ifdef I2S_LEFT_JUSTIFIED_EN
        sd_idx     = 5'd31 - pos;
        sdata_nxt  = slot[sd_idx];
        lrclk_nxt  = ~bit_nxt[5];
`else
        sd_idx     = 5'd0 - pos;
        sdata_nxt  = (pos == 5'd0) ? 1'b0 : slot[sd_idx];
        lrclk_nxt  = bit_nxt[5];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_cnt      <= '0;
            bit_cnt      <= 6'd63;
            hold         <= '0;
            o_bclk       <= 1'b0;
            o_lrclk      <= 1'b0;
            o_sdata      <= 1'b0;
            o_sample_req <= 1'b0;
        end else begin
            o_sample_req <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                o_bclk  <= ~o_bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            // Data and word select change only as BCLK falls; the DAC samples on the rise.
            if (fall_tick) begin
                bit_cnt <= bit_nxt;
                o_lrclk <= lrclk_nxt;
                o_sdata <= sdata_nxt;
                if (frame_wrap) begin
                    hold         <= i_sample;
                    o_sample_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: frames are queued as expected slot words and a
// monitor rebuilds words from o_sdata at BCLK rises; a second monitor checks clock timing.
`timescale 1ns/1ps
module tb_i2s_transmitter;

    localparam int HALF = 8;
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic LEFT_LVL = 1'b1;
`else
    localparam logic LEFT_LVL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] i_sample;
    logic        o_sample_req;
    logic        o_bclk;
    logic        o_lrclk;
    logic        o_sdata;

    i2s_transmitter #(.BCLK_HALF_DIV(HALF), .SLOT_BITS(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_sample     (i_sample),
        .o_sample_req (o_sample_req),
        .o_bclk       (o_bclk),
        .o_lrclk      (o_lrclk),
        .o_sdata      (o_sdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] word);
        exp_q.push_back({LEFT_LVL == 1'b0, word});
        exp_q.push_back({LEFT_LVL == 1'b1, word});
    endtask

    task automatic emit(input logic is_left, input logic [31:0] word);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL word_unexpected: got left=%0b %08h, expected nothing", is_left, word);
        end else begin
            e = exp_q.pop_front();
            check("slot_word", {is_left, word}, e);
        end
    endtask

    // Word monitor: reassembles each channel at the rise where LRCLK has changed.
    logic [31:0] sh;
    int          nbits;
    logic        w_prev_lr;
    logic        w_prev_bclk;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            sh = '0;
            nbits = 0;
            w_prev_lr = 1'b0;
            w_prev_bclk = 1'b0;
        end else begin
            if (o_bclk && !w_prev_bclk) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
                if (o_lrclk != w_prev_lr && nbits >= 32) emit(w_prev_lr == LEFT_LVL, sh);
                sh = {sh[30:0], o_sdata};
                nbits++;
`else
                sh = {sh[30:0], o_sdata};
                nbits++;
                if (o_lrclk != w_prev_lr && nbits >= 32) emit(w_prev_lr == LEFT_LVL, sh);
`endif
                w_prev_lr = o_lrclk;
            end
            w_prev_bclk = o_bclk;
        end
    end

    // Timing monitor: BCLK, LRCLK and sample request periods.
    int   cyc = 0;
    int   t_req = -1;
    int   t_bclk = -1;
    int   t_lr = -1;
    logic t_pb;
    logic t_plr;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            t_req = -1;
            t_bclk = -1;
            t_lr = -1;
            t_pb = 1'b0;
            t_plr = 1'b0;
        end else begin
            if (o_sample_req) begin
                if (t_req >= 0) check("req_period", cyc - t_req, 64'd1024);
                t_req = cyc;
            end
            if (o_bclk && !t_pb) begin
                if (t_bclk >= 0) check("bclk_period", cyc - t_bclk, 64'd16);
                t_bclk = cyc;
            end
            if (o_lrclk && !t_plr) begin
                if (t_lr >= 0) check("lrclk_period", cyc - t_lr, 64'd1024);
                t_lr = cyc;
            end
            if (!o_lrclk && t_plr && t_lr >= 0) check("lrclk_high", cyc - t_lr, 64'd512);
            t_pb = o_bclk;
            t_plr = o_lrclk;
        end
    end

    task automatic check_reset_state();
        check("rst_bclk", o_bclk, 64'd0);
        check("rst_lrclk", o_lrclk, 64'd0);
        check("rst_sdata", o_sdata, 64'd0);
        check("rst_req", o_sample_req, 64'd0);
        check("rst_bit_cnt", dut.bit_cnt, 64'd63);
        check("rst_div_cnt", dut.div_cnt, 64'd0);
        check("rst_hold", dut.hold, 64'd0);
    endtask

    // Called right after reset is released; covers the first frame boundary.
    task automatic check_startup();
        int rise_at = -1;
        int fall_at = -1;
        int req_at = -1;
        int req_n = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (o_bclk && rise_at < 0) rise_at = k;
            if (!o_bclk && rise_at >= 0 && fall_at < 0) fall_at = k;
            if (o_sample_req) begin
                req_n++;
                req_at = k;
            end
        end
        check("first_bclk_rise", rise_at, 64'd8);
        check("first_bclk_fall", fall_at, 64'd16);
        check("first_req_cycle", req_at, 64'd16);
        check("first_req_count", req_n, 64'd1);
        check("first_lrclk", o_lrclk, {63'd0, LEFT_LVL});
        check("first_bit_cnt", dut.bit_cnt, 64'd0);
    endtask

    task automatic wait_req(input string name);
        logic got = 1'b0;
        for (int k = 0; k < 2048 && !got; k++) begin
            @(posedge clk);
            #1;
            got = o_sample_req;
        end
        check(name, got, 64'd1);
    endtask

    task automatic wait_falls(input int n);
        int   seen = 0;
        logic pb = o_bclk;
        for (int k = 0; k < 4096 && seen < n; k++) begin
            @(posedge clk);
            #1;
            if (pb && !o_bclk) seen++;
            pb = o_bclk;
        end
        check("bclk_falls", seen, n);
    endtask

    task automatic send_frame(input logic [23:0] smp, input logic [31:0] word);
        i_sample = smp;
        push_frame(word);
        wait_req("req_seen");
    endtask

    initial begin
        rst = 1'b1;
        i_sample = 24'h000000;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_reset_state();
        end
        i_sample = 24'hA5C3F1;
        push_frame(32'hA5C3F100);
        @(negedge clk);
        rst = 1'b0;
        check_startup();

        send_frame(24'hA5C3F1, 32'hA5C3F100);
        send_frame(24'h123456, 32'h12345600);
        send_frame(24'hFFFFFF, 32'hFFFFFF00);
        send_frame(24'h7FFFFF, 32'h7FFFFF00);

        // Mid-frame input change must not disturb the frame in flight.
        send_frame(24'h800000, 32'h80000000);
        wait_falls(10);
        i_sample = 24'h000001;
        push_frame(32'h00000100);
        wait_req("req_after_change");

        // One-cycle reset at bit 40: the pending right word is abandoned.
        wait_falls(40);
        check("pending_before_reset", exp_q.size(), 64'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        i_sample = 24'hA5C3F1;
        push_frame(32'hA5C3F100);
        @(negedge clk);
        rst = 1'b0;
        check_startup();

        send_frame(24'h654321, 32'h65432100);
        wait_req("req_drain");
        repeat (20) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
